// File: rtl/ysyx_23060020_pkg.sv
// rtl/ysyx_23060020_pkg.sv - shared constants, state enum and pc helper for the IFU
package ysyx_23060020_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    ERR
  } ifu_state_e;

  // jalr semantics: bit 0 of the target is always dropped
  function automatic logic [31:0] redirect_pc(input logic [31:0] target);
    return {target[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_23060020_reg.sv
// rtl/ysyx_23060020_reg.sv - width-parametrised register with sync active-low reset and write enable
module ysyx_23060020_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_23060020_ifu.sv
// rtl/ysyx_23060020_ifu.sv - single-outstanding instruction fetch unit with sticky fault state
module ysyx_23060020_ifu
  import ysyx_23060020_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instw,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        jump_bool,
  input  logic [31:0] jump_target,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  ifu_state_e  state;
  logic        retire;
  logic        rsp_ok;
  logic        misaligned;
  logic [31:0] next_pc;

  // HOLD is the only state with inst_valid high, so it qualifies the handshake
  assign retire     = (state == HOLD) && inst_ready;
  assign rsp_ok     = (state == WAIT) && imem_rvalid && !imem_err;
  assign next_pc    = jump_bool ? redirect_pc(jump_target) : pc + 32'd4;
  assign misaligned = jump_bool && next_pc[1];
  assign imem_addr  = pc;

  ysyx_23060020_reg #(
    .WIDTH    (32),
    .RESET_VAL(RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst_n(rst_n),
    .wen  (retire),
    .din  (next_pc),
    .dout (pc)
  );

  ysyx_23060020_reg #(
    .WIDTH    (32),
    .RESET_VAL(INST_NOP)
  ) u_instw (
    .clk  (clk),
    .rst_n(rst_n),
    .wen  (rsp_ok),
    .din  (imem_rdata),
    .dout (instw)
  );

  ysyx_23060020_reg #(
    .WIDTH    (32),
    .RESET_VAL(32'h0)
  ) u_fetch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .wen  (retire),
    .din  (fetch_cnt + 32'd1),
    .dout (fetch_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (imem_err) begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end else begin
              state      <= HOLD;
              inst_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            if (misaligned) begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state      <= ERR;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          fetch_err  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060020_ifu.sv
// tb/tb_ysyx_23060020_ifu.sv - randomized scoreboard bench for the instruction fetch unit
module tb_ysyx_23060020_ifu;
  import ysyx_23060020_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_err = 1'b0;
  logic [31:0] instw;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        jump_bool = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int vectors = 0;
  int miscompares = 0;
  int handshakes = 0;

  always #5 clk = ~clk;

  ysyx_23060020_ifu #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .imem_err   (imem_err),
    .instw      (instw),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .jump_bool  (jump_bool),
    .jump_target(jump_target),
    .fetch_err  (fetch_err),
    .fetch_cnt  (fetch_cnt)
  );

  // expected instruction words, pushed by the memory responder
  logic [31:0] exp_q[$];
  logic [31:0] dir_data[$];
  logic [32:0] dir_jumps[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: protocol phase plus architectural pc/instw/count
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_instw = INST_NOP;
  logic [31:0] m_cnt = 32'h0;
  bit m_idle = 1'b1, m_pend = 1'b0, m_valid = 1'b0, m_err = 1'b0;

  always @(negedge clk) begin
    check("imem_req", 32'(imem_req), 32'(!m_idle && !m_pend && !m_valid && !m_err));
    check("imem_addr", imem_addr, m_pc);
    check("pc", pc, m_pc);
    check("instw", instw, m_instw);
    check("inst_valid", 32'(inst_valid), 32'(m_valid));
    check("fetch_err", 32'(fetch_err), 32'(m_err));
    check("fetch_cnt", fetch_cnt, m_cnt);
    if (!rst_n) begin
      m_pc = RST_PC; m_instw = INST_NOP; m_cnt = 32'h0;
      m_idle = 1'b1; m_pend = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_pend) begin
      if (imem_rvalid) begin
        m_pend = 1'b0;
        if (imem_err) begin
          m_err = 1'b1;
        end else begin
          check("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) m_instw = exp_q.pop_front();
          m_valid = 1'b1;
        end
      end
    end else if (m_valid) begin
      if (inst_ready) begin
        handshakes++;
        m_valid = 1'b0;
        m_cnt = m_cnt + 32'd1;
        if (jump_bool) begin
          m_pc = jump_target & 32'hFFFF_FFFE;
          if (m_pc[1]) m_err = 1'b1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end else if (imem_gnt) begin
      m_pend = 1'b1;
    end
  end

  // stimulus knobs and responder state
  int unsigned gnt_pct, ready_pct, max_lat, err_pct, mis_pct, jump_pct, stray_pct;
  int unsigned lat;
  bit pend = 1'b0, granted = 1'b0, stray_after = 1'b0;

  task automatic drive_cycle();
    int unsigned r;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (granted) begin
      pend = 1'b1;
      lat  = $urandom_range(0, max_lat);
    end
    granted     = 1'b0;
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = $urandom;
    if (stray_after) begin
      imem_rvalid = 1'b1;
      imem_err    = 1'($urandom_range(0, 1));
      stray_after = 1'b0;
    end else if (pend) begin
      if (lat == 0) begin
        if (dir_data.size() != 0) imem_rdata = dir_data.pop_front();
        imem_rvalid = 1'b1;
        imem_err    = ($urandom_range(0, 99) < err_pct);
        if (!imem_err) exp_q.push_back(imem_rdata);
        pend = 1'b0;
      end else begin
        lat = lat - 1;
      end
    end else if ($urandom_range(0, 99) < stray_pct) begin
      imem_rvalid = 1'b1;
      imem_err    = 1'($urandom_range(0, 1));
    end
    imem_gnt = imem_req && ($urandom_range(0, 99) < gnt_pct);
    granted  = imem_gnt;

    inst_ready = ($urandom_range(0, 99) < ready_pct);
    jump_bool  = ($urandom_range(0, 99) < jump_pct);
    r = $urandom_range(0, 99);
    if (r < mis_pct) jump_target = $urandom | 32'h2;
    else if (r < mis_pct + 15) jump_target = 32'hFFFF_FFFC | 32'($urandom_range(0, 1));
    else jump_target = $urandom & 32'hFFFF_FFFD;
    if (inst_valid && inst_ready && dir_jumps.size() != 0)
      {jump_bool, jump_target} = dir_jumps.pop_front();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) drive_cycle();
  endtask

  task automatic apply_reset(input bit in_wait);
    if (in_wait)
      for (int k = 0; k < 50 && !(pend || granted); k++) drive_cycle();
    stray_after = pend || granted;
    pend = 1'b0;
    granted = 1'b0;
    dir_data.delete();
    dir_jumps.delete();
    @(posedge clk); #1;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0;
    inst_ready = 1'($urandom_range(0, 1)); jump_bool = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    imem_rvalid = stray_after; imem_rdata = $urandom;
  endtask

  initial begin
    apply_reset(1'b0);

    // directed walk: plain fetch, odd redirect, wrap at top of memory, misaligned fault
    gnt_pct = 100; ready_pct = 100; max_lat = 0; err_pct = 0;
    mis_pct = 0; jump_pct = 0; stray_pct = 0;
    dir_data.push_back(32'h0010_0093);
    dir_jumps.push_back({1'b0, 32'h0});
    dir_jumps.push_back({1'b1, 32'h8000_0101});
    dir_jumps.push_back({1'b1, 32'hFFFF_FFFC});
    dir_jumps.push_back({1'b0, 32'h0});
    dir_jumps.push_back({1'b1, 32'h8000_0102});
    run(40);
    check("dir_fetch_err", 32'(fetch_err), 32'd1);
    check("dir_fetch_cnt", fetch_cnt, 32'd5);
    check("dir_pc", pc, 32'h8000_0102);
    check("dir_req_dead", 32'(imem_req), 32'd0);
    apply_reset(1'b0);

    for (int i = 0; i < 25; i++) begin
      gnt_pct   = $urandom_range(15, 100);
      ready_pct = $urandom_range(15, 100);
      max_lat   = $urandom_range(0, 3);
      err_pct   = $urandom_range(0, 3);
      mis_pct   = $urandom_range(0, 2);
      jump_pct  = $urandom_range(0, 40);
      stray_pct = $urandom_range(0, 40);
      run(int'($urandom_range(100, 300)));
      apply_reset((i % 3) == 0);
    end
    run(4);

    check("progress", 32'(handshakes >= 100), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_23060020_ifu.md
YSYX_23060020_IFU -- requirements
Module: ysyx_23060020_ifu

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  synchronous, active-low reset.
REQ-005 Port: imem_req  out  1  fetch request to instruction memory.
REQ-006 Port: imem_addr  out  32  fetch address; equals pc.
REQ-007 Port: imem_gnt  in  1  memory accepts the request this cycle.
REQ-008 Port: imem_rvalid  in  1  read data valid.
REQ-009 Port: imem_rdata  in  32  fetched instruction word.
REQ-010 Port: imem_err  in  1  bus error; qualified by imem_rvalid.
REQ-011 Port: instw  out  32  instruction word to the decoder.
REQ-012 Port: pc  out  32  address of the instruction currently on instw.
REQ-013 Port: inst_valid  out  1  instw/pc hold a valid instruction.
REQ-014 Port: inst_ready  in  1  downstream retires the instruction this cycle.
REQ-015 Port: jump_bool  in  1  retiring instruction redirects the pc (jal/jalr).
REQ-016 Port: jump_target  in  32  redirect address; sampled only with jump_bool.
REQ-017 Port: fetch_err  out  1  sticky fetch-fault flag.
REQ-018 Port: fetch_cnt  out  32  count of retired instructions.

Function
REQ-019 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and ERR.
REQ-020 IDLE: no request is made; the FSM goes to REQ on the next cycle.
REQ-021 REQ: imem_req=1 and imem_addr=pc; on imem_gnt=1 the FSM goes to WAIT, otherwise it stays in REQ with the address held stable.
REQ-022 WAIT: imem_req=0; on imem_rvalid=1 with imem_err=0 the block SHALL latch instw<=imem_rdata and go to HOLD; on imem_rvalid=1 with imem_err=1 it goes to ERR.
REQ-023 HOLD: inst_valid=1, and instw/pc SHALL stay stable until inst_valid&&inst_ready.
REQ-024 On the retire handshake in HOLD: pc<=jump_bool ? {jump_target[31:1],1'b0} : pc+32'd4, fetch_cnt increments, and the FSM goes to REQ.
REQ-025 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 fetch_cnt SHALL wrap modulo 2^32.
REQ-027 A redirect target with bit1=1 after bit0 is cleared SHALL load pc and go to ERR (misaligned).
REQ-028 ERR: imem_req=0, inst_valid=0 and fetch_err=1, sticky until reset.
REQ-029 imem_rvalid SHALL be ignored in IDLE, REQ, HOLD and ERR.
REQ-030 imem_rvalid in the same cycle as imem_gnt SHALL be ignored; memory latency is at least 1 cycle.
REQ-031 Minimum latency SHALL be 2 cycles from the REQ cycle with gnt to inst_valid=1; peak throughput is 1 instruction per 3 cycles.
REQ-032 jump_bool and jump_target SHALL be ignored when no handshake occurs.
REQ-033 Exactly one fetch SHALL be outstanding at a time; no flush logic exists.

Reset
REQ-034 On rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, instw=32'h0000_0013 (nop), inst_valid=0, imem_req=0, fetch_err=0, fetch_cnt=0.
REQ-035 Reset asserted in WAIT SHALL abandon the fetch; a late imem_rvalid after reset SHALL be ignored.
REQ-036 The first request after reset SHALL occur on the second clock after rst_n rises, with imem_addr=RESET_PC.

Structure
REQ-037 Package ysyx_23060020_pkg SHALL hold the RESET_PC default, the INST_NOP constant (32'h0000_0013) and the IFU state enum.
REQ-038 The pc SHALL be held in one sub-module, ysyx_23060020_reg: a parametrised-width register with synchronous active-low reset value and write-enable; instw and fetch_cnt reuse it.

Verification
REQ-039 Reset release, gnt immediate, rvalid 1 cycle later with 32'h00100093, inst_ready=1 -> imem_addr=8000_0000; instw=00100093 with pc=8000_0000; next imem_addr=8000_0004.
REQ-040 Handshake with jump_bool=1, jump_target=8000_0101 -> next imem_addr=8000_0100 and fetch_err=0.
REQ-041 Handshake with jump_bool=1, jump_target=8000_0102 -> ERR state, fetch_err=1, imem_req stays 0 thereafter, recovered only by rst_n=0.
REQ-042 gnt withheld 5 cycles, then inst_ready held 0 for 4 cycles -> imem_addr stable during the stall; instw/pc stable and inst_valid=1 throughout HOLD.
REQ-043 rst_n=0 during WAIT followed by a stray rvalid -> ignored; refetch from 8000_0000; fetch_cnt=0.
REQ-044 Redirect to FFFF_FFFC, retire without jump -> imem_addr=0000_0000; fetch_cnt increments by 2 across the two handshakes.
